// File: rtl/coef_serializer.sv
// Parallel-to-serial converter for DCT coefficient vectors feeding the RLE encoder.
// Two banks: ACT drains one coefficient per beat while PND holds the next vector.
module coef_serializer #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned N      = 8,
   parameter int unsigned IDX_W  = $clog2(N)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                rev,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N*DATA_W-1:0] in_vec,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [IDX_W-1:0]    out_idx,
   output logic                out_last
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   logic [DATA_W-1:0] in_elem [N];
   logic [DATA_W-1:0] act_q   [N];
   logic [DATA_W-1:0] act_d   [N];
   logic [DATA_W-1:0] pnd_q   [N];
   logic [DATA_W-1:0] pnd_d   [N];

   logic              act_full_q, act_full_d;
   logic              pnd_full_q, pnd_full_d;
   logic              act_rev_q, act_rev_d;
   logic              pnd_rev_q, pnd_rev_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  sel_d;
   logic [DATA_W-1:0] out_data_d;
   logic [IDX_W-1:0]  out_idx_d;

   logic              in_fire;
   logic              out_fire;
   logic              idx_at_last;
   logic              act_free;

   for (genvar k = 0; k < N; k++) begin : g_unpack
      assign in_elem[k] = in_vec[k*DATA_W +: DATA_W];
   end

   assign out_valid   = act_full_q;
   assign in_fire     = in_valid & in_ready;
   assign out_fire    = act_full_q & out_ready;
   assign idx_at_last = (idx_q == IDX_LAST);
   assign act_free    = !act_full_q | (out_fire & idx_at_last);

   // Next-state: drain, PND->ACT refill, accept, then flush overrides everything.
   always_comb begin
      act_d      = act_q;
      pnd_d      = pnd_q;
      act_full_d = act_full_q;
      pnd_full_d = pnd_full_q;
      act_rev_d  = act_rev_q;
      pnd_rev_d  = pnd_rev_q;
      idx_d      = idx_q;
      out_data_d = out_data;
      out_idx_d  = out_idx;

      if (out_fire) begin
         if (idx_at_last) begin
            idx_d      = '0;
            act_full_d = 1'b0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end

      if (act_free && pnd_full_q) begin
         act_d      = pnd_q;
         act_rev_d  = pnd_rev_q;
         act_full_d = 1'b1;
         idx_d      = '0;
         pnd_full_d = 1'b0;
      end

      if (in_fire) begin
         if (act_free && !pnd_full_q) begin
            act_d      = in_elem;
            act_rev_d  = rev;
            act_full_d = 1'b1;
            idx_d      = '0;
         end else begin
            pnd_d      = in_elem;
            pnd_rev_d  = rev;
            pnd_full_d = 1'b1;
         end
      end

      if (flush) begin
         act_full_d = 1'b0;
         pnd_full_d = 1'b0;
         idx_d      = '0;
      end

      // Output data/index only move while a vector is live; they hold when empty.
      sel_d = act_rev_d ? (IDX_LAST - idx_d) : idx_d;
      if (act_full_d) begin
         out_data_d = act_d[sel_d];
         out_idx_d  = idx_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            act_q[k] <= '0;
            pnd_q[k] <= '0;
         end
         act_full_q <= 1'b0;
         pnd_full_q <= 1'b0;
         act_rev_q  <= 1'b0;
         pnd_rev_q  <= 1'b0;
         idx_q      <= '0;
         in_ready   <= 1'b1;
         out_data   <= '0;
         out_idx    <= '0;
         out_last   <= 1'b0;
      end else begin
         act_q      <= act_d;
         pnd_q      <= pnd_d;
         act_full_q <= act_full_d;
         pnd_full_q <= pnd_full_d;
         act_rev_q  <= act_rev_d;
         pnd_rev_q  <= pnd_rev_d;
         idx_q      <= idx_d;
         in_ready   <= !pnd_full_d;
         out_data   <= out_data_d;
         out_idx    <= out_idx_d;
         out_last   <= act_full_d & (idx_d == IDX_LAST);
      end
   end

endmodule

// File: doc/coef_serializer.md
Name: coef_serializer

Overview:
- Parallel-to-serial converter for DCT coefficient blocks.
- Accepts one N-coefficient vector per handshake from the DCT stage and emits it one coefficient per cycle to the RLE encoder.
- Double-buffered, so a new vector can be accepted while the previous one drains.
- Provides valid/ready flow control on both sides, an end-of-block marker, and an optional reversed emission order.

Parameters:
- DATA_W, 12: bit width of each coefficient.
- N, 8: coefficients per vector; must be at least 2.
- IDX_W, $clog2(N): width of the element index.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous; discards both banks.
- rev  input  1  emission order for vectors accepted while this is high: 0 emits element 0 first, 1 emits element N-1 first.
- in_valid  input  1  in_vec holds a valid vector.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  N*DATA_W  packed vector; element k is at bits [k*DATA_W +: DATA_W].
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_W  current coefficient.
- out_idx  output  IDX_W  position of the current coefficient within its vector, 0..N-1 in emission order.
- out_last  output  1  high with the final coefficient of a vector.

Behaviour:
- Storage:
  - Two banks, ACT (draining) and PND (pending).
  - Each bank has a full flag and a stored rev bit.
  - ACT has an index counter idx, range 0..N-1.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - act_free = !act_full | (out_fire & idx==N-1).
- in_ready = !pnd_full. It is a registered-state function with no combinational path from in_valid.
- On in_fire:
  - If act_free and PND is empty, the vector loads into ACT directly. act_full is set, idx is cleared, and rev is captured.
  - Otherwise the vector loads into PND and pnd_full is set.
- When act_free and pnd_full: PND moves to ACT, idx is cleared, and pnd_full is cleared. An in_fire in the same cycle then writes PND.
- Latency: out_valid rises one cycle after the accepting edge. With out_ready held high, back-to-back vectors stream with no gap cycles.
- Outputs:
  - out_valid = act_full.
  - out_idx = idx.
  - out_data = ACT element idx when stored rev is 0, else element N-1-idx.
  - out_last = act_full & idx==N-1.
- idx advances only on out_fire. It wraps from N-1 to 0, and act_full clears at the wrap unless PND refills ACT.
- Backpressure: while out_ready is low, out_data, out_idx and out_last hold stable and idx does not change.
- Fullness: with both banks full, in_ready is low and in_vec is ignored. No data is lost or overwritten.
- Empty: out_valid is low, and out_data and out_idx hold their last values; downstream must not sample them.
- flush:
  - Clears act_full, pnd_full and idx on the next edge and overrides a simultaneous in_fire. A vector presented that cycle is dropped.
  - in_ready is 1 on the following cycle.
- rev changes take effect only for subsequently accepted vectors; a vector in flight keeps its captured order.
- reset, asserted at any time including mid-vector:
  - Immediately forces out_valid=0, out_last=0, out_idx=0, out_data=0 and in_ready=1.
  - Clears both banks, all flags and idx.
  - After deassertion the block behaves as freshly started, and the first vector accepted emits from index 0.
- Arithmetic: pure data movement with no sign or width change; coefficients pass bit-exact.

Test Plan:
- Single vector, default order: reset, then present in_vec = {7,6,5,4,3,2,1,0} (element k = k) once with out_ready=1.
  - out_data must be 0,1,...,7 on 8 consecutive cycles starting 1 cycle after accept, with out_idx 0..7 and out_last only with 7.
- Streaming: present vectors A (all 0x0A1) and B (all 0xFFF) back-to-back with out_ready=1.
  - Expect 16 consecutive valid beats with no gap; in_ready stays high except never low for more than the PND occupancy.
- Backpressure and full: accept 2 vectors with out_ready=0.
  - in_ready must go low and a 3rd vector must not be taken.
  - out_data must hold element 0 unchanged for 10 cycles.
  - Release out_ready: all 16 values emerge in order, then the 3rd vector is accepted.
- Reverse mode: rev=1 with element k = 0x100+k.
  - Expect output 0x107 down to 0x100, with out_idx 0..7 and out_last with 0x100.
  - Toggle rev mid-drain: the current vector's order is unchanged.
- Flush and reset mid-vector: after 3 beats, pulse flush.
  - out_valid goes low next cycle and in_ready=1.
  - Repeat with reset asserted asynchronously between clock edges: all outputs are 0 immediately, and the next vector emits from index 0.
- Parameter sweep: N=4 with DATA_W=16, and N=16 with DATA_W=12.
  - Repeat the single-vector, streaming and backpressure cases; check wrap at N-1 and bit-exact data.
